// File: rtl/fe_fb_arb_pkg.sv
// Shared types and constants for the fetch-buffer arbiter.
//   t_fb_owner      : which requester owns an outstanding transaction
//   t_fb_arb_entry  : one outstanding-table entry {vld, owner, stale, addr}
//   FB_ARB_*        : default sizing constants
package fe_fb_arb_pkg;

  localparam int FB_ARB_PADDR_W    = 32;
  localparam int FB_ARB_NUM_OUTST  = 4;
  localparam int FB_ARB_ID_W       = $clog2(FB_ARB_NUM_OUTST);
  localparam int FB_ARB_STARVE_MAX = 7;

  typedef enum logic {
    FB_OWN_D = 1'b0,
    FB_OWN_P = 1'b1
  } t_fb_owner;

  typedef struct packed {
    logic                      vld;
    t_fb_owner                 owner;
    logic                      stale;
    logic [FB_ARB_PADDR_W-1:0] addr;
  } t_fb_arb_entry;

endpackage

// File: rtl/fe_fb_arb_if.sv
// Bundle of all request/response/status signals of the fetch-buffer arbiter.
// Handshake semantics: a request transfers on a cycle where its valid and the
// matching accept (d_req_rdy / p_req_rdy / fb_req_rdy) are both high; the
// accept may depend combinationally on valid. Responses have no backpressure:
// fb_rsp_valid, d_rsp_valid and p_rsp_valid are single-cycle events.
//   slave  : the arbiter's view
//   master : the environment's view (requesters + fetch buffer)
interface fe_fb_arb_if #(
  parameter int PADDR_W = 32,
  parameter int ID_W    = 2
);
  logic               d_req_valid;
  logic [PADDR_W-1:0] d_req_addr;
  logic               d_req_rdy;
  logic               p_req_valid;
  logic [PADDR_W-1:0] p_req_addr;
  logic               p_req_rdy;
  logic               fb_req_valid;
  logic [PADDR_W-1:0] fb_req_addr;
  logic [ID_W-1:0]    fb_req_id;
  logic               fb_req_rdy;
  logic               fb_rsp_valid;
  logic [ID_W-1:0]    fb_rsp_id;
  logic [PADDR_W-1:0] fb_rsp_pc;
  logic [31:0]        fb_rsp_instr;
  logic               d_rsp_valid;
  logic               p_rsp_valid;
  logic [PADDR_W-1:0] rsp_pc;
  logic [31:0]        rsp_instr;
  logic               flush;
  logic [ID_W:0]      outst_cnt;
  logic               err_bad_id;

  modport slave (
    input  d_req_valid, d_req_addr, p_req_valid, p_req_addr, fb_req_rdy,
           fb_rsp_valid, fb_rsp_id, fb_rsp_pc, fb_rsp_instr, flush,
    output d_req_rdy, p_req_rdy, fb_req_valid, fb_req_addr, fb_req_id,
           d_rsp_valid, p_rsp_valid, rsp_pc, rsp_instr, outst_cnt, err_bad_id
  );

  modport master (
    output d_req_valid, d_req_addr, p_req_valid, p_req_addr, fb_req_rdy,
           fb_rsp_valid, fb_rsp_id, fb_rsp_pc, fb_rsp_instr, flush,
    input  d_req_rdy, p_req_rdy, fb_req_valid, fb_req_addr, fb_req_id,
           d_rsp_valid, p_rsp_valid, rsp_pc, rsp_instr, outst_cnt, err_bad_id
  );
endinterface

// File: rtl/fe_fb_arb_tbl.sv
// Outstanding-transaction table.
//   alloc_*    : write a fresh entry at free_id (caller guarantees free_vld)
//   rsp_en/id  : release the entry at rsp_id
//   flush      : mark every valid entry stale
//   match_addr : looked up against valid, non-stale entries -> match_hit
//   free_vld/free_id : lowest free index from registered state
//   rsp_entry  : registered contents of entry rsp_id
//   outst_cnt  : number of valid entries (registered state)
module fe_fb_arb_tbl
  import fe_fb_arb_pkg::*;
#(
  parameter int NUM_OUTST = FB_ARB_NUM_OUTST,
  parameter int ID_W      = $clog2(NUM_OUTST)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      alloc_en,
  input  t_fb_owner                 alloc_owner,
  input  logic [FB_ARB_PADDR_W-1:0] alloc_addr,
  input  logic                      rsp_en,
  input  logic [ID_W-1:0]           rsp_id,
  input  logic                      flush,
  input  logic [FB_ARB_PADDR_W-1:0] match_addr,
  output logic                      free_vld,
  output logic [ID_W-1:0]           free_id,
  output logic                      match_hit,
  output t_fb_arb_entry             rsp_entry,
  output logic [ID_W:0]             outst_cnt
);

  t_fb_arb_entry [NUM_OUTST-1:0] tbl_q, tbl_d;

  // Lookups use registered state only, so an entry released this cycle is
  // not seen as free until the next one.
  always_comb begin
    free_vld  = 1'b0;
    free_id   = '0;
    match_hit = 1'b0;
    outst_cnt = '0;
    for (int i = NUM_OUTST - 1; i >= 0; i--) begin
      if (!tbl_q[i].vld) begin
        free_vld = 1'b1;
        free_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_OUTST; i++) begin
      if (tbl_q[i].vld && !tbl_q[i].stale && (tbl_q[i].addr == match_addr))
        match_hit = 1'b1;
      outst_cnt = outst_cnt + (ID_W+1)'(tbl_q[i].vld);
    end
  end

  assign rsp_entry = tbl_q[rsp_id];

  always_comb begin
    tbl_d = tbl_q;
    for (int i = 0; i < NUM_OUTST; i++) begin
      if (flush && tbl_q[i].vld)
        tbl_d[i].stale = 1'b1;
      if (rsp_en && (rsp_id == ID_W'(i)))
        tbl_d[i].vld = 1'b0;
      // The allocated index is free in registered state, so it never
      // collides with the released one.
      if (alloc_en && (free_id == ID_W'(i))) begin
        tbl_d[i].vld   = 1'b1;
        tbl_d[i].owner = alloc_owner;
        tbl_d[i].stale = 1'b0;
        tbl_d[i].addr  = alloc_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) tbl_q <= '0;
    else          tbl_q <= tbl_d;
  end

endmodule

// File: rtl/fe_fb_arb.sv
// Fetch-buffer request arbiter between demand fetch (D) and next-line
// prefetch (P). Allocates transaction ids, dedups prefetches that hit an
// in-flight line, routes out-of-order responses back to their owner and
// squashes in-flight responses on flush.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : fe_fb_arb_if.slave (request, fetch-buffer, response,
//                  flush and status signals)
module fe_fb_arb
  import fe_fb_arb_pkg::*;
#(
  parameter int PADDR_W    = FB_ARB_PADDR_W,
  parameter int NUM_OUTST  = FB_ARB_NUM_OUTST,
  parameter int STARVE_MAX = FB_ARB_STARVE_MAX,
  localparam int ID_W      = $clog2(NUM_OUTST),
  localparam int STARVE_W  = $clog2(STARVE_MAX + 1)
) (
  input logic        clk,
  input logic        reset_n,
  fe_fb_arb_if.slave bus
);

  logic                starve_max;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                err_bad_id_q, err_bad_id_d;
  logic                free_vld, match_hit;
  logic [ID_W-1:0]     free_id;
  logic [ID_W:0]       outst_cnt;
  t_fb_arb_entry       rsp_entry;
  logic                grant_ok, p_win, d_win, p_dedup, fb_valid, issue;
  logic                rsp_hit;
  logic [PADDR_W-1:0]  win_addr;

  assign starve_max = (starve_cnt_q == STARVE_W'(STARVE_MAX));

  // Every combinational output is qualified by reset_n so the block is
  // silent while reset is asserted regardless of what the inputs do.
  assign grant_ok = reset_n && !bus.flush && free_vld;
  assign p_win    = grant_ok && bus.p_req_valid && (starve_max || !bus.d_req_valid);
  assign d_win    = grant_ok && bus.d_req_valid && !p_win;
  assign p_dedup  = p_win && match_hit;
  assign fb_valid = d_win || (p_win && !p_dedup);
  assign issue    = fb_valid && bus.fb_req_rdy;
  assign win_addr = p_win ? bus.p_req_addr : bus.d_req_addr;

  assign bus.fb_req_valid = fb_valid;
  assign bus.fb_req_addr  = fb_valid ? win_addr : '0;
  assign bus.fb_req_id    = fb_valid ? free_id : '0;
  assign bus.d_req_rdy    = d_win && bus.fb_req_rdy;
  assign bus.p_req_rdy    = p_win && (p_dedup || bus.fb_req_rdy);

  assign rsp_hit          = reset_n && bus.fb_rsp_valid && rsp_entry.vld;
  assign bus.d_rsp_valid  = rsp_hit && !rsp_entry.stale && (rsp_entry.owner == FB_OWN_D);
  assign bus.p_rsp_valid  = rsp_hit && !rsp_entry.stale && (rsp_entry.owner == FB_OWN_P);
  assign bus.rsp_pc       = reset_n ? bus.fb_rsp_pc : '0;
  assign bus.rsp_instr    = reset_n ? bus.fb_rsp_instr : '0;
  assign bus.outst_cnt    = outst_cnt;
  assign bus.err_bad_id   = err_bad_id_q;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (bus.flush || !bus.p_req_valid || bus.p_req_rdy)
      starve_cnt_d = '0;
    else if (!starve_max)
      starve_cnt_d = starve_cnt_q + 1'b1;
    err_bad_id_d = err_bad_id_q || (bus.fb_rsp_valid && !rsp_entry.vld);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt_q <= '0;
      err_bad_id_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      err_bad_id_q <= err_bad_id_d;
    end
  end

  fe_fb_arb_tbl #(.NUM_OUTST(NUM_OUTST), .ID_W(ID_W)) u_tbl (
    .clk         (clk),
    .reset_n     (reset_n),
    .alloc_en    (issue),
    .alloc_owner (p_win ? FB_OWN_P : FB_OWN_D),
    .alloc_addr  (win_addr),
    .rsp_en      (rsp_hit),
    .rsp_id      (bus.fb_rsp_id),
    .flush       (bus.flush),
    .match_addr  (bus.p_req_addr),
    .free_vld    (free_vld),
    .free_id     (free_id),
    .match_hit   (match_hit),
    .rsp_entry   (rsp_entry),
    .outst_cnt   (outst_cnt)
  );

endmodule

// File: tb/tb_fe_fb_arb.sv
// Directed bench for fe_fb_arb. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_fe_fb_arb;

  logic clk;
  logic reset_n;
  int   vecs;
  int   errs;

  fe_fb_arb_if #(.PADDR_W(32), .ID_W(2)) bus ();

  fe_fb_arb dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.d_req_valid  = 1'b0;
    bus.d_req_addr   = '0;
    bus.p_req_valid  = 1'b0;
    bus.p_req_addr   = '0;
    bus.fb_req_rdy   = 1'b0;
    bus.fb_rsp_valid = 1'b0;
    bus.fb_rsp_id    = '0;
    bus.fb_rsp_pc    = '0;
    bus.fb_rsp_instr = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    #3;
    if (bus.fb_req_valid !== 1'b0) begin $display("FAIL rst_fb_valid: got %0h exp 0", bus.fb_req_valid); errs++; end vecs++;
    if (bus.outst_cnt !== 3'd0) begin $display("FAIL rst_outst: got %0d exp 0", bus.outst_cnt); errs++; end vecs++;
    if (bus.err_bad_id !== 1'b0) begin $display("FAIL rst_err: got %0h exp 0", bus.err_bad_id); errs++; end vecs++;
    if ({bus.d_rsp_valid, bus.p_rsp_valid, bus.d_req_rdy, bus.p_req_rdy} !== 4'b0) begin
      $display("FAIL rst_misc: got %0h exp 0", {bus.d_rsp_valid, bus.p_rsp_valid, bus.d_req_rdy, bus.p_req_rdy}); errs++;
    end vecs++;
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h100; bus.fb_req_rdy = 1'b1;
    @(negedge clk);
    if (bus.fb_req_valid !== 1'b1) begin $display("FAIL basic_fb_valid: got %0h exp 1", bus.fb_req_valid); errs++; end vecs++;
    if (bus.fb_req_id !== 2'd0) begin $display("FAIL basic_id: got %0d exp 0", bus.fb_req_id); errs++; end vecs++;
    if (bus.fb_req_addr !== 32'h100) begin $display("FAIL basic_addr: got %0h exp 100", bus.fb_req_addr); errs++; end vecs++;
    if (bus.d_req_rdy !== 1'b1 || bus.p_req_rdy !== 1'b0) begin
      $display("FAIL basic_rdy: got d=%0h p=%0h exp d=1 p=0", bus.d_req_rdy, bus.p_req_rdy); errs++;
    end vecs++;
    tick();
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd1) begin $display("FAIL basic_outst1: got %0d exp 1", bus.outst_cnt); errs++; end vecs++;
    tick();
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'd0; bus.fb_rsp_pc = 32'h100; bus.fb_rsp_instr = 32'hdeadbeef;
    @(negedge clk);
    if (bus.d_rsp_valid !== 1'b1 || bus.p_rsp_valid !== 1'b0) begin
      $display("FAIL basic_rsp: got d=%0h p=%0h exp d=1 p=0", bus.d_rsp_valid, bus.p_rsp_valid); errs++;
    end vecs++;
    if (bus.rsp_pc !== 32'h100 || bus.rsp_instr !== 32'hdeadbeef) begin
      $display("FAIL basic_rsp_data: got %0h/%0h exp 100/deadbeef", bus.rsp_pc, bus.rsp_instr); errs++;
    end vecs++;
    tick();
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd0) begin $display("FAIL basic_outst0: got %0d exp 0", bus.outst_cnt); errs++; end vecs++;
    tick();
  endtask

  task automatic test_starve();
    logic [1:0] prev_id;
    logic [1:0] exp_id;
    logic       exp_p;
    prev_id = 2'd0;
    for (int k = 1; k <= 9; k++) begin
      idle();
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h300;
      bus.p_req_valid = 1'b1; bus.p_req_addr = 32'h400;
      bus.fb_req_rdy  = 1'b1;
      bus.fb_rsp_valid = (k > 1); bus.fb_rsp_id = prev_id;
      exp_id = 2'((k - 1) % 2);
      exp_p  = (k == 8);
      @(negedge clk);
      if (bus.fb_req_id !== exp_id) begin $display("FAIL starve_id[%0d]: got %0d exp %0d", k, bus.fb_req_id, exp_id); errs++; end vecs++;
      if (bus.p_req_rdy !== exp_p || bus.d_req_rdy !== !exp_p) begin
        $display("FAIL starve_grant[%0d]: got d=%0h p=%0h exp p=%0h", k, bus.d_req_rdy, bus.p_req_rdy, exp_p); errs++;
      end vecs++;
      if (bus.fb_req_addr !== (exp_p ? 32'h400 : 32'h300)) begin
        $display("FAIL starve_addr[%0d]: got %0h exp %0h", k, bus.fb_req_addr, exp_p ? 32'h400 : 32'h300); errs++;
      end vecs++;
      if (k == 2 && bus.d_rsp_valid !== 1'b1) begin $display("FAIL starve_drsp: got %0h exp 1", bus.d_rsp_valid); errs++; end
      if (k == 2) vecs++;
      if (k == 9 && (bus.p_rsp_valid !== 1'b1 || bus.d_rsp_valid !== 1'b0)) begin
        $display("FAIL starve_prsp: got d=%0h p=%0h exp d=0 p=1", bus.d_rsp_valid, bus.p_rsp_valid); errs++;
      end
      if (k == 9) vecs++;
      tick();
      prev_id = exp_id;
    end
    idle();
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = prev_id;
    @(negedge clk);
    if (bus.d_rsp_valid !== 1'b1) begin $display("FAIL starve_last_rsp: got %0h exp 1", bus.d_rsp_valid); errs++; end vecs++;
    tick();
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd0) begin $display("FAIL starve_outst: got %0d exp 0", bus.outst_cnt); errs++; end vecs++;
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      idle();
      bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h1000 + 32'(i * 4); bus.fb_req_rdy = 1'b1;
      @(negedge clk);
      if (bus.fb_req_id !== 2'(i) || bus.d_req_rdy !== 1'b1) begin
        $display("FAIL full_fill[%0d]: got id=%0d rdy=%0h exp id=%0d rdy=1", i, bus.fb_req_id, bus.d_req_rdy, i); errs++;
      end vecs++;
      tick();
    end
    bus.d_req_addr = 32'h2000;
    @(negedge clk);
    if (bus.d_req_rdy !== 1'b0 || bus.fb_req_valid !== 1'b0) begin
      $display("FAIL full_block: got rdy=%0h fbv=%0h exp 0/0", bus.d_req_rdy, bus.fb_req_valid); errs++;
    end vecs++;
    if (bus.outst_cnt !== 3'd4) begin $display("FAIL full_outst: got %0d exp 4", bus.outst_cnt); errs++; end vecs++;
    tick();
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'd2;
    @(negedge clk);
    if (bus.d_req_rdy !== 1'b0 || bus.d_rsp_valid !== 1'b1) begin
      $display("FAIL full_same_cycle: got rdy=%0h drsp=%0h exp 0/1", bus.d_req_rdy, bus.d_rsp_valid); errs++;
    end vecs++;
    tick();
    bus.fb_rsp_valid = 1'b0;
    @(negedge clk);
    if (bus.fb_req_id !== 2'd2 || bus.d_req_rdy !== 1'b1) begin
      $display("FAIL full_realloc: got id=%0d rdy=%0h exp id=2 rdy=1", bus.fb_req_id, bus.d_req_rdy); errs++;
    end vecs++;
    tick();
    idle();
    for (int i = 0; i < 4; i++) begin
      bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'(i);
      tick();
    end
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd0) begin $display("FAIL full_drain: got %0d exp 0", bus.outst_cnt); errs++; end vecs++;
    tick();
  endtask

  task automatic test_dedup();
    idle();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h200; bus.fb_req_rdy = 1'b1;
    @(negedge clk);
    if (bus.fb_req_id !== 2'd0 || bus.d_req_rdy !== 1'b1) begin
      $display("FAIL dedup_issue: got id=%0d rdy=%0h exp 0/1", bus.fb_req_id, bus.d_req_rdy); errs++;
    end vecs++;
    tick();
    idle();
    bus.p_req_valid = 1'b1; bus.p_req_addr = 32'h200; bus.fb_req_rdy = 1'b0;
    @(negedge clk);
    if (bus.p_req_rdy !== 1'b1 || bus.fb_req_valid !== 1'b0) begin
      $display("FAIL dedup_hit: got prdy=%0h fbv=%0h exp 1/0", bus.p_req_rdy, bus.fb_req_valid); errs++;
    end vecs++;
    tick();
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd1) begin $display("FAIL dedup_outst: got %0d exp 1", bus.outst_cnt); errs++; end vecs++;
    tick();
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'd0;
    tick();
    idle();
    tick();
  endtask

  task automatic test_flush();
    idle();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h500; bus.fb_req_rdy = 1'b1;
    tick();
    idle();
    bus.p_req_valid = 1'b1; bus.p_req_addr = 32'h600; bus.fb_req_rdy = 1'b1;
    @(negedge clk);
    if (bus.p_req_rdy !== 1'b1 || bus.fb_req_id !== 2'd1) begin
      $display("FAIL flush_p_issue: got rdy=%0h id=%0d exp 1/1", bus.p_req_rdy, bus.fb_req_id); errs++;
    end vecs++;
    tick();
    idle();
    bus.flush = 1'b1; bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h700; bus.fb_req_rdy = 1'b1;
    @(negedge clk);
    if (bus.fb_req_valid !== 1'b0 || bus.d_req_rdy !== 1'b0) begin
      $display("FAIL flush_no_grant: got fbv=%0h rdy=%0h exp 0/0", bus.fb_req_valid, bus.d_req_rdy); errs++;
    end vecs++;
    tick();
    for (int i = 0; i < 2; i++) begin
      idle();
      bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'(i);
      @(negedge clk);
      if (bus.d_rsp_valid !== 1'b0 || bus.p_rsp_valid !== 1'b0) begin
        $display("FAIL flush_squash[%0d]: got d=%0h p=%0h exp 0/0", i, bus.d_rsp_valid, bus.p_rsp_valid); errs++;
      end vecs++;
      tick();
    end
    idle();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd0 || bus.err_bad_id !== 1'b0) begin
      $display("FAIL flush_freed: got cnt=%0d err=%0h exp 0/0", bus.outst_cnt, bus.err_bad_id); errs++;
    end vecs++;
    tick();
  endtask

  task automatic test_bad_id_and_reset();
    idle();
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'd3;
    @(negedge clk);
    if (bus.d_rsp_valid !== 1'b0 || bus.p_rsp_valid !== 1'b0) begin
      $display("FAIL bad_rsp: got d=%0h p=%0h exp 0/0", bus.d_rsp_valid, bus.p_rsp_valid); errs++;
    end vecs++;
    tick();
    idle();
    @(negedge clk);
    if (bus.err_bad_id !== 1'b1) begin $display("FAIL bad_err_set: got %0h exp 1", bus.err_bad_id); errs++; end vecs++;
    tick();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h800; bus.fb_req_rdy = 1'b1;
    tick();
    idle();
    @(negedge clk);
    if (bus.err_bad_id !== 1'b1 || bus.outst_cnt !== 3'd1) begin
      $display("FAIL bad_err_hold: got err=%0h cnt=%0d exp 1/1", bus.err_bad_id, bus.outst_cnt); errs++;
    end vecs++;
    tick();
    bus.d_req_valid = 1'b1; bus.d_req_addr = 32'h900; bus.fb_req_rdy = 1'b1;
    bus.fb_rsp_valid = 1'b1; bus.fb_rsp_id = 2'd0; bus.fb_rsp_pc = 32'h800; bus.fb_rsp_instr = 32'h13;
    #1;
    reset_n = 1'b0;
    #1;
    if (bus.outst_cnt !== 3'd0 || bus.err_bad_id !== 1'b0) begin
      $display("FAIL midrst_state: got cnt=%0d err=%0h exp 0/0", bus.outst_cnt, bus.err_bad_id); errs++;
    end vecs++;
    if ({bus.fb_req_valid, bus.d_req_rdy, bus.d_rsp_valid, bus.p_rsp_valid} !== 4'b0 || bus.rsp_pc !== 32'h0 || bus.fb_req_addr !== 32'h0) begin
      $display("FAIL midrst_outs: got %0h pc=%0h addr=%0h exp 0", {bus.fb_req_valid, bus.d_req_rdy, bus.d_rsp_valid, bus.p_rsp_valid}, bus.rsp_pc, bus.fb_req_addr); errs++;
    end vecs++;
    idle();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    @(negedge clk);
    if (bus.outst_cnt !== 3'd0 || bus.err_bad_id !== 1'b0) begin
      $display("FAIL postrst: got cnt=%0d err=%0h exp 0/0", bus.outst_cnt, bus.err_bad_id); errs++;
    end vecs++;
    tick();
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    test_reset();
    test_basic();
    test_starve();
    test_full();
    test_dedup();
    test_flush();
    test_bad_id_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fe_fb_arb.md
Name: fe_fb_arb

Overview:
- Shares the single fetch-buffer request port between two requesters: the front-end demand fetch (D) and a next-line instruction prefetcher (P).
- Allocates a transaction id per issued request and tracks outstanding requests in a small table.
- Routes out-of-order fetch-buffer responses back to the owning requester.
- Squashes in-flight responses on branch mispredict.
- Sits between fe_ctl / prefetcher and the fetch buffer.

Parameters:
- PADDR_W, 32, physical address width.
- NUM_OUTST, 4, outstanding-table entries; power of 2, ≥2.
- ID_W, $clog2(NUM_OUTST), transaction id width.
- STARVE_MAX, 7, cycles a blocked P request waits before it takes priority over D.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- d_req_valid  in  1  demand request valid.
- d_req_addr  in  PADDR_W  demand address.
- d_req_rdy  out  1  demand request accepted this cycle.
- p_req_valid  in  1  prefetch request valid.
- p_req_addr  in  PADDR_W  prefetch address.
- p_req_rdy  out  1  prefetch request accepted (issued or deduplicated).
- fb_req_valid  out  1  request to fetch buffer.
- fb_req_addr  out  PADDR_W  address to fetch buffer.
- fb_req_id  out  ID_W  allocated id.
- fb_req_rdy  in  1  fetch buffer accepts request.
- fb_rsp_valid  in  1  fetch-buffer response valid.
- fb_rsp_id  in  ID_W  response id.
- fb_rsp_pc  in  PADDR_W  response PC.
- fb_rsp_instr  in  32  response instruction.
- d_rsp_valid  out  1  response to demand requester.
- p_rsp_valid  out  1  response to prefetcher.
- rsp_pc  out  PADDR_W  shared response PC.
- rsp_instr  out  32  shared response instruction.
- flush  in  1  branch mispredict flush.
- outst_cnt  out  ID_W+1  number of valid table entries.
- err_bad_id  out  1  sticky: response arrived for an invalid entry.

Behaviour:
- Reset (async, reset_n=0): table cleared, starve counter 0, err_bad_id 0, all outputs 0.
- Table entry fields: vld, owner (D/P), stale, addr.
  - Free id = lowest index with vld=0, evaluated on the registered state.
  - An entry freed by a response this cycle is not reallocated until the next cycle.
- Grant (combinational, zero latency):
  - No grant if flush=1 or no free entry.
  - Otherwise P wins if p_req_valid and starve_cnt==STARVE_MAX; else D wins if d_req_valid; else P wins if p_req_valid.
- fb_req_valid = grant exists, except a P grant that deduplicates (see P dedup) never drives fb_req_valid. fb_req_addr/fb_req_id come from the winner and the free id.
- Issue occurs when fb_req_valid & fb_req_rdy.
  - Entry set: vld=1, owner, addr, stale=0.
  - d_req_rdy / p_req_rdy assert for the issuing requester only.
- P dedup: if P is granted and p_req_addr matches the addr of any vld & ~stale entry, then:
  - p_req_rdy=1 and fb_req_valid=0 that cycle;
  - no allocation, and fb_req_rdy is ignored.
- Starve counter:
  - Increments (saturating at STARVE_MAX) while p_req_valid & ~p_req_rdy.
  - Clears on p_req_rdy or when p_req_valid=0.
- Response handling (fb_rsp_valid), combinational routing:
  - If entry[fb_rsp_id].vld: d_rsp_valid=(owner==D & ~stale), p_rsp_valid=(owner==P & ~stale); entry freed at clock edge.
  - If the entry is not vld: both rsp valids are 0 and err_bad_id sets (sticky until reset).
  - rsp_pc/rsp_instr pass straight from fb_rsp_* every cycle.
  - Requesters never backpressure responses.
- Flush:
  - All vld entries get stale=1 at the edge; the starve counter clears.
  - A response arriving in the flush cycle is still delivered if its entry is not already stale.
  - A request issued in the same cycle is impossible, because grant is suppressed.
- Simultaneous issue and response on different ids: both take effect. outst_cnt reflects registered state.

Decomposition:
- Shared package mem_common gains:
  - t_fb_owner enum {FB_OWN_D, FB_OWN_P};
  - t_fb_arb_entry struct {vld, owner, stale, addr};
  - FB_ARB_NUM_OUTST constant.
- One natural sub-module: fe_fb_arb_tbl, which holds the entry array, free-id priority encoder, address-match compare and outst_cnt. Arbitration and starvation logic stay in the top module.

Test Plan:
- Reset, then D req addr 0x100 with fb_req_rdy=1 → fb_req_valid=1, id=0, d_req_rdy=1. Response id 0, pc 0x100 → d_rsp_valid=1, outst_cnt returns 0.
- D and P valid together for 8 cycles, fb_req_rdy=1, responses returned immediately. P granted on the 8th cycle (starve_cnt reaches 7) → p_req_rdy=1, then starve_cnt clears.
- Fill all 4 ids with D requests (fb_req_rdy=1, no responses) → 5th request gets d_req_rdy=0, outst_cnt=4. Response id 2 → id 2 is reallocated on the following cycle, not the same cycle.
- Issue D 0x200 as id 0, then P 0x200 → p_req_rdy=1, fb_req_valid=0, outst_cnt stays 1.
- Issue ids 0 and 1, assert flush, then return both responses → d_rsp_valid and p_rsp_valid stay 0 for both, entries freed, outst_cnt=0.
- Response with id 3 while the table is empty → no rsp valid, err_bad_id=1 and it holds. Assert reset_n=0 mid-stream → all outputs 0 immediately.
